// File: rtl/uart_tx_core.sv
// rtl/uart_tx_core.sv - UART transmitter with built-in oversampling baud divider
//
// Sends one frame per accepted start strobe: start bit, DATA_BITS data bits
// LSB first, optional parity bit, then a stop period of STOP_TICKS ticks.
// One bit lasts 16 oversample ticks; one tick lasts BAUD_DIV clk cycles.
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous, active-high reset
//   tx_start     in   active-low start strobe, sampled in idle and in the done cycle
//   data_byte    in   byte to send, sampled only when the strobe is accepted
//   tx           out  registered serial line, idles high
//   tx_done_tick out  one-cycle pulse on the final clk of the stop period
//   busy         out  high from start acceptance through the done cycle

module uart_tx_core #(
    parameter int BAUD_DIV   = 326,
    parameter int DATA_BITS  = 8,
    parameter int STOP_TICKS = 16,
    parameter int PARITY     = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] data_byte,
    output logic       tx,
    output logic       tx_done_tick,
    output logic       busy
);

    localparam int DIV_W  = $clog2(BAUD_DIV);
    // Tick counter must hold both 0..15 (one bit) and 0..STOP_TICKS-1.
    localparam int TICK_W = $clog2((STOP_TICKS > 16) ? STOP_TICKS : 16);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(BAUD_DIV - 1);
    localparam logic [TICK_W-1:0] BIT_LAST  = TICK_W'(15);
    localparam logic [TICK_W-1:0] STOP_LAST = TICK_W'(STOP_TICKS - 1);
    localparam logic [2:0]        DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [7:0]        DATA_MASK = 8'((1 << DATA_BITS) - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [2:0]          bit_q, bit_d;
    logic [7:0]          shift_q, shift_d;
    logic                par_q, par_d;
    logic                tx_q, tx_d;

    logic                baud_tick;
    logic                bit_end;
    logic                stop_end;
    logic                accept;
    logic                done;
    logic [7:0]          masked_data;

    assign baud_tick   = (div_q == DIV_LAST);
    assign bit_end     = baud_tick && (tick_q == BIT_LAST);
    assign stop_end    = baud_tick && (tick_q == STOP_LAST);
    assign masked_data = data_byte & DATA_MASK;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = 1'b1;
        accept  = 1'b0;
        done    = 1'b0;

        // Divider and tick counter run only while a frame is in flight.
        if (state_q != S_IDLE) begin
            div_d = baud_tick ? '0 : div_q + 1'b1;
            if (baud_tick) begin
                tick_d = tick_q + 1'b1;
            end
        end

        // tx_d is the line level for the current state; tx_q lags state by one clk.
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (!tx_start) begin
                    accept = 1'b1;
                end
            end
            S_START: begin
                tx_d = 1'b0;
                if (bit_end) begin
                    state_d = S_DATA;
                    tick_d  = '0;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                tx_d = shift_q[0];
                if (bit_end) begin
                    tick_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                tx_d = par_q;
                if (bit_end) begin
                    tick_d  = '0;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                tx_d = 1'b1;
                if (stop_end) begin
                    done    = 1'b1;
                    tick_d  = '0;
                    state_d = S_IDLE;
                    // Framer answers the done tick combinationally; chain straight into start.
                    if (!tx_start) begin
                        accept = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (accept) begin
            state_d = S_START;
            div_d   = '0;
            tick_d  = '0;
            bit_d   = '0;
            shift_d = masked_data;
            // XOR of data is 1 when the data holds an odd number of ones.
            par_d   = (PARITY == 1) ? ~(^masked_data) : (^masked_data);
        end
    end

    assign tx           = tx_q;
    assign tx_done_tick = done;
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_core.sv
// tb/tb_uart_tx_core.sv - scoreboard testbench for uart_tx_core

module tb_uart_tx_core;

    localparam int NI      = 5;
    localparam int BD      = 2;
    localparam int BIT_CLK = 16 * BD;

    function automatic int db_of(input int i);
        return (i == 4) ? 5 : 8;
    endfunction

    function automatic int par_of(input int i);
        return (i == 1 || i == 3) ? 2 : ((i == 2) ? 1 : 0);
    endfunction

    function automatic int stp_of(input int i);
        return (i == 3) ? 32 : 16;
    endfunction

    function automatic int frame_cycles(input int i);
        return (1 + db_of(i) + ((par_of(i) != 0) ? 1 : 0)) * BIT_CLK + stp_of(i) * BD;
    endfunction

    // Expected frame: bits[15:0] = start, data LSB first, optional parity; [23:16] = bit count.
    function automatic logic [23:0] model_frame(input logic [7:0] d, input int db, input int par);
        logic [15:0] b;
        int n;
        int ones;
        b = '0;
        n = 1;
        ones = 0;
        for (int k = 0; k < db; k++) begin
            b[n] = d[k];
            ones += int'(d[k]);
            n++;
        end
        if (par == 1) begin
            b[n] = ((ones % 2) == 0);
            n++;
        end else if (par == 2) begin
            b[n] = ((ones % 2) == 1);
            n++;
        end
        return {8'(n), b};
    endfunction

    logic              clk;
    logic              reset;
    logic [NI-1:0]     tx_start;
    logic [7:0]        data_byte [NI];
    logic [NI-1:0]     tx_w;
    logic [NI-1:0]     done_w;
    logic [NI-1:0]     busy_w;

    logic [23:0]       exp_q [NI][$];
    bit                mon_active [NI];
    int                stray [NI];
    int                n_checks = 0;
    int                n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < NI; gi++) begin : g
        uart_tx_core #(
            .BAUD_DIV  (BD),
            .DATA_BITS (db_of(gi)),
            .STOP_TICKS(stp_of(gi)),
            .PARITY    (par_of(gi))
        ) dut (
            .clk         (clk),
            .reset       (reset),
            .tx_start    (tx_start[gi]),
            .data_byte   (data_byte[gi]),
            .tx          (tx_w[gi]),
            .tx_done_tick(done_w[gi]),
            .busy        (busy_w[gi])
        );

        int          idx, len, nb, first_bad, done_cnt, done_at, busy_err;
        logic [15:0] bits;
        logic [23:0] e;
        logic        exp_lvl;
        bit          junk;

        // Monitor: a falling tx line starts a frame; pop its expectation and check it to the end.
        always @(negedge clk) begin
            if (reset) begin
                mon_active[gi] = 1'b0;
                junk = 1'b0;
            end else begin
                if (!mon_active[gi] && !junk && tx_w[gi] == 1'b0) begin
                    chk($sformatf("frame_queued%0d", gi), (exp_q[gi].size() > 0) ? 1 : 0, 1);
                    if (exp_q[gi].size() == 0) begin
                        junk = 1'b1;
                    end else begin
                        e = exp_q[gi].pop_front();
                        bits = e[15:0];
                        nb = int'(e[23:16]);
                        len = nb * BIT_CLK + stp_of(gi) * BD;
                        idx = 0;
                        first_bad = -1;
                        done_cnt = 0;
                        done_at = -1;
                        busy_err = 0;
                        mon_active[gi] = 1'b1;
                    end
                end
                if (mon_active[gi]) begin
                    exp_lvl = (idx < nb * BIT_CLK) ? bits[idx / BIT_CLK] : 1'b1;
                    if (tx_w[gi] !== exp_lvl && first_bad < 0) first_bad = idx;
                    if (done_w[gi]) begin
                        done_cnt++;
                        done_at = idx;
                    end
                    if (idx <= len - 2 && busy_w[gi] !== 1'b1) busy_err++;
                    idx++;
                    if (idx == len) begin
                        chk($sformatf("wave_first_bad_sample%0d", gi), first_bad, -1);
                        chk($sformatf("done_count%0d", gi), done_cnt, 1);
                        chk($sformatf("done_position%0d", gi), done_at, len - 2);
                        chk($sformatf("busy_low_in_frame%0d", gi), busy_err, 0);
                        mon_active[gi] = 1'b0;
                    end
                end else if (done_w[gi]) begin
                    if (junk) junk = 1'b0;
                    else stray[gi]++;
                end
            end
        end
    end

    task automatic issue(input int i, input logic [7:0] d);
        tx_start[i] = 1'b0;
        data_byte[i] = d;
        exp_q[i].push_back(model_frame(d, db_of(i), par_of(i)));
    endtask

    // Called on a negedge; returns on the negedge where tx_done_tick is seen.
    task automatic frame(input int i, input logic [7:0] d, input int ign_at);
        int cyc;
        cyc = 0;
        issue(i, d);
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                tx_start[i] = 1'b1;
                data_byte[i] = 8'($urandom);
                chk($sformatf("lat_tx_high%0d", i), int'(tx_w[i]), 1);
                chk($sformatf("lat_busy%0d", i), int'(busy_w[i]), 1);
            end
            if (cyc == 2) chk($sformatf("lat_tx_low%0d", i), int'(tx_w[i]), 0);
            if (ign_at > 0 && cyc == ign_at) begin
                tx_start[i] = 1'b0;
                data_byte[i] = 8'hFF;
            end
            if (ign_at > 0 && cyc == ign_at + 1) tx_start[i] = 1'b1;
        end while (!done_w[i] && cyc < 4000);
        chk($sformatf("done_cycle%0d", i), cyc, frame_cycles(i));
    endtask

    initial begin
        int viol;
        int gap;
        reset = 1'b1;
        tx_start = '1;
        for (int i = 0; i < NI; i++) data_byte[i] = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_tx", int'(tx_w), (1 << NI) - 1);
        chk("reset_busy", int'(busy_w), 0);
        chk("reset_done", int'(done_w), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single 0xA5 frame
        frame(0, 8'hA5, 0);
        repeat (2) @(negedge clk);
        chk("idle_after_a5", int'(busy_w[0]), 0);

        // Back-to-back 0x3C then 0x81 issued in the done cycle
        frame(0, 8'h3C, 0);
        frame(0, 8'h81, 0);
        repeat (2) @(negedge clk);
        chk("idle_after_b2b", int'(busy_w[0]), 0);

        // Strobe with 0xFF mid-frame must be ignored
        frame(0, 8'h3C, 100);
        repeat (3) @(negedge clk);
        chk("idle_after_ignored", int'(busy_w[0]), 0);

        // Parity and long stop variants
        frame(1, 8'h07, 0);
        frame(2, 8'h07, 0);
        frame(3, 8'h07, 0);
        frame(4, 8'hE6, 0);
        repeat (3) @(negedge clk);

        // Reset mid-frame
        issue(0, 8'hA5);
        @(negedge clk);
        tx_start[0] = 1'b1;
        repeat (149) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_tx", int'(tx_w[0]), 1);
        chk("abort_busy", int'(busy_w[0]), 0);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        repeat (5) @(negedge clk);
        frame(0, 8'h5A, 0);
        repeat (3) @(negedge clk);

        // Long idle
        viol = 0;
        repeat (1000) begin
            @(negedge clk);
            if (tx_w !== '1 || busy_w !== '0 || done_w !== '0) viol++;
        end
        chk("idle_violations", viol, 0);

        // Randomized frames with random gaps, including back-to-back chains
        for (int i = 0; i < NI; i++) begin
            for (int k = 0; k < 4; k++) begin
                frame(i, 8'($urandom), 0);
                gap = $urandom_range(0, 3);
                if (gap > 0) repeat (gap) @(negedge clk);
            end
            repeat (3) @(negedge clk);
            chk($sformatf("idle_after_random%0d", i), int'(busy_w[i]), 0);
        end

        repeat (5) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("queue_empty%0d", i), exp_q[i].size(), 0);
            chk($sformatf("stray_done%0d", i), stray[i], 0);
            chk($sformatf("monitor_idle%0d", i), int'(mon_active[i]), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
